// File: rtl/cpu_io_port.sv
// cpu_io_port: console I/O peripheral between the CPU strobes and a host.
// Input FIFO feeds in_data; the output FIFO drains to the host by valid/ready.
`timescale 1ns/1ps
module cpu_io_port #(
  parameter int WIDTH     = 64,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         host_in_valid,
  output logic                         host_in_ready,
  input  logic [WIDTH-1:0]             host_in_data,
  input  logic                         in_signal,
  output logic [WIDTH-1:0]             in_data,
  input  logic                         out_signal,
  input  logic [WIDTH-1:0]             out_data,
  output logic                         host_out_valid,
  input  logic                         host_out_ready,
  output logic [WIDTH-1:0]             host_out_data,
  output logic [$clog2(IN_DEPTH):0]    in_count,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
  output logic                         underflow,
  output logic                         overflow,
  input  logic                         clear_flags
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [IAW:0] IN_FULL = (IAW+1)'(IN_DEPTH);
  localparam logic [OAW:0] OUT_FULL = (OAW+1)'(OUT_DEPTH);

  logic             in_q;
  logic             in_q_d;
  logic             out_q;
  logic             out_q_d;
  logic             in_evt;
  logic             out_evt;

  logic [WIDTH-1:0] in_mem [IN_DEPTH];
  logic [IAW-1:0]   in_wr;
  logic [IAW-1:0]   in_rd;
  logic             in_full;
  logic             in_empty;
  logic             in_push;
  logic             in_pop;

  logic [WIDTH-1:0] out_mem [OUT_DEPTH];
  logic [OAW-1:0]   out_wr;
  logic [OAW-1:0]   out_rd;
  logic             out_full;
  logic             out_empty;
  logic             out_push;
  logic             out_pop;

  // Strobes are registered twice; an event is the registered rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q    <= 1'b0;
      in_q_d  <= 1'b0;
      out_q   <= 1'b0;
      out_q_d <= 1'b0;
    end else begin
      in_q    <= in_signal;
      in_q_d  <= in_q;
      out_q   <= out_signal;
      out_q_d <= out_q;
    end
  end

  assign in_evt  = in_q & ~in_q_d;
  assign out_evt = out_q & ~out_q_d;

  assign in_full   = (in_count == IN_FULL);
  assign in_empty  = (in_count == '0);
  assign in_push   = host_in_valid & ~in_full;
  assign in_pop    = in_evt & ~in_empty;

  assign host_in_ready = ~in_full;
  assign in_data       = in_empty ? '0 : in_mem[in_rd];

  // Input storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= host_in_data;
  end

  // Input pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr    <= '0;
      in_rd    <= '0;
      in_count <= '0;
    end else begin
      if (in_push) in_wr <= in_wr + 1'b1;
      if (in_pop)  in_rd <= in_rd + 1'b1;
      unique case ({in_push, in_pop})
        2'b10:   in_count <= in_count + 1'b1;
        2'b01:   in_count <= in_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign out_full  = (out_count == OUT_FULL);
  assign out_empty = (out_count == '0);
  assign out_push  = out_evt & ~out_full;
  assign out_pop   = host_out_ready & ~out_empty;

  assign host_out_valid = ~out_empty;
  assign host_out_data  = out_empty ? '0 : out_mem[out_rd];

  // Output storage captures out_data in the cycle the edge is seen.
  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr] <= out_data;
  end

  // Output pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
    end else begin
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
      unique case ({out_push, out_pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky error flags; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      underflow <= (underflow & ~clear_flags) | (in_evt & in_empty);
      overflow  <= (overflow & ~clear_flags) | (out_evt & out_full);
    end
  end

endmodule

// File: tb/tb_cpu_io_port.sv
// tb_cpu_io_port: directed and random stimulus against a queue-based model
// of the console port.
`timescale 1ns/1ps
module tb_cpu_io_port;

  localparam int W  = 64;
  localparam int ID = 8;
  localparam int OD = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          host_in_valid = 1'b0;
  logic          host_in_ready;
  logic [W-1:0]  host_in_data = '0;
  logic          in_signal = 1'b0;
  logic [W-1:0]  in_data;
  logic          out_signal = 1'b0;
  logic [W-1:0]  out_data = '0;
  logic          host_out_valid;
  logic          host_out_ready = 1'b0;
  logic [W-1:0]  host_out_data;
  logic [3:0]    in_count;
  logic [3:0]    out_count;
  logic          underflow;
  logic          overflow;
  logic          clear_flags = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mi[$];
  logic [W-1:0] mo[$];
  bit muf, mov;
  bit m_in_prev, m_in_evt, m_out_prev, m_out_evt;

  cpu_io_port #(.WIDTH(W), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clk(clk), .reset(reset),
    .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_in_data(host_in_data), .in_signal(in_signal),
    .in_data(in_data), .out_signal(out_signal), .out_data(out_data),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .host_out_data(host_out_data), .in_count(in_count),
    .out_count(out_count), .underflow(underflow),
    .overflow(overflow), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    mi.delete();
    mo.delete();
    muf = 0; mov = 0;
    m_in_prev = 0; m_in_evt = 0;
    m_out_prev = 0; m_out_evt = 0;
  endtask

  // A strobe rising between two clock samples acts on the following edge.
  task automatic model_edge();
    bit ie, oe, nuf, nov;
    int ni, no;
    logic [W-1:0] d;
    ie = m_in_evt; oe = m_out_evt;
    ni = mi.size(); no = mo.size();
    nuf = 0; nov = 0;
    m_in_evt   = in_signal && !m_in_prev;
    m_in_prev  = in_signal;
    m_out_evt  = out_signal && !m_out_prev;
    m_out_prev = out_signal;
    if (host_in_valid && ni < ID) mi.push_back(host_in_data);
    if (ie) begin
      if (ni > 0) d = mi.pop_front();
      else nuf = 1;
    end
    if (host_out_ready && no > 0) d = mo.pop_front();
    if (oe) begin
      if (no == OD) nov = 1;
      else mo.push_back(out_data);
    end
    muf = (muf && !clear_flags) || nuf;
    mov = (mov && !clear_flags) || nov;
  endtask

  task automatic compare_all();
    check("in_data", in_data, mi.size() > 0 ? mi[0] : 64'd0);
    check("in_count", 64'(in_count), 64'(mi.size()));
    check("host_in_ready", 64'(host_in_ready), 64'(mi.size() < ID));
    check("host_out_valid", 64'(host_out_valid), 64'(mo.size() > 0));
    check("host_out_data", host_out_data, mo.size() > 0 ? mo[0] : 64'd0);
    check("out_count", 64'(out_count), 64'(mo.size()));
    check("underflow", 64'(underflow), 64'(muf));
    check("overflow", 64'(overflow), 64'(mov));
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cpu_in();
    in_signal = 1'b1; step();
    in_signal = 1'b0; step();
    step();
  endtask

  task automatic cpu_out(input logic [W-1:0] w);
    out_data = w;
    out_signal = 1'b1; step(); step();
    out_signal = 1'b0; step();
  endtask

  task automatic host_push(input logic [W-1:0] w);
    host_in_valid = 1'b1; host_in_data = w; step();
    host_in_valid = 1'b0;
  endtask

  logic [W-1:0] seq [3];

  initial begin
    model_reset();
    step(); step();
    reset = 1'b1;
    repeat (5) step();
    check("idle_in_data", in_data, 64'd0);
    check("idle_ready", 64'(host_in_ready), 64'd1);

    host_push(64'h11); host_push(64'h22); host_push(64'h33);
    check("in_head", in_data, 64'h11);
    seq[0] = 64'h22; seq[1] = 64'h33; seq[2] = 64'h0;
    for (int i = 0; i < 3; i++) begin
      in_signal = 1'b1; step();
      in_signal = 1'b0; step();
      check("in_seq", in_data, seq[i]);
      check("in_seq_cnt", 64'(in_count), 64'(2 - i));
      step();
    end
    check("in_seq_uf", 64'(underflow), 64'd0);

    for (int i = 0; i < 9; i++) host_push(64'(100 + i));
    check("full_ready", 64'(host_in_ready), 64'd0);
    check("full_cnt", 64'(in_count), 64'd8);
    for (int i = 0; i < 9; i++) cpu_in();
    check("uf_set", 64'(underflow), 64'd1);
    check("uf_data", in_data, 64'd0);
    clear_flags = 1'b1; step();
    clear_flags = 1'b0;
    check("uf_clr", 64'(underflow), 64'd0);

    host_push(64'hA1); host_push(64'hA2);
    in_signal = 1'b1;
    repeat (4) step();
    in_signal = 1'b0;
    repeat (3) step();
    check("held_cnt", 64'(in_count), 64'd1);
    in_signal = 1'b1; step(); in_signal = 1'b0; step(); step();

    cpu_out(64'hDEAD); cpu_out(64'hBEEF);
    check("oq_cnt", 64'(out_count), 64'd2);
    check("oq_head", host_out_data, 64'hDEAD);
    host_out_ready = 1'b1; step();
    check("oq_second", host_out_data, 64'hBEEF);
    step();
    check("oq_empty", 64'(host_out_valid), 64'd0);
    host_out_ready = 1'b0;

    for (int i = 0; i < 8; i++) cpu_out(64'(i + 1));
    cpu_out(64'hFF);
    check("ov_set", 64'(overflow), 64'd1);
    check("ov_cnt", 64'(out_count), 64'd8);
    host_out_ready = 1'b1;
    repeat (9) begin
      step();
      check("ov_drop", 64'(host_out_data == 64'hFF), 64'd0);
    end
    host_out_ready = 1'b0;
    cpu_out(64'h5); cpu_out(64'h6); host_push(64'h77);
    @(posedge clk);
    model_edge();
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all();
    check("rst_ov", 64'(overflow), 64'd0);
    check("rst_ocnt", 64'(out_count), 64'd0);
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 3000; i++) begin
      host_in_valid  = ($urandom % 2) == 0;
      host_in_data   = {$urandom, $urandom};
      host_out_ready = (i < 1500) ? (($urandom % 4) == 0)
                                  : (($urandom % 4) != 0);
      in_signal      = ($urandom % 3) == 0;
      if (!out_signal) out_data = {$urandom, $urandom};
      out_signal     = ($urandom % 3) == 0;
      clear_flags    = ($urandom % 16) == 0;
      reset          = ($urandom % 400) != 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
